// File: rtl/fv_req_scheduler_if.sv
// Request-scheduler bus: request FIFO pop side, bank busy flags, issue outputs and statistics.
// FIFO handshake: the scheduler pulses fifo_rinc only while fifo_empty=0; the FIFO answers with fifo_valid (plus tag/addr) exactly one cycle later.
interface fv_req_scheduler_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int TAG_W     = 2,
  parameter int CNT_W     = 16
);
  localparam int SEL_W   = $clog2(NUM_BANKS);
  localparam int LADDR_W = ADDR_W - SEL_W;

  logic                 fifo_empty;
  logic                 fifo_valid;
  logic [TAG_W-1:0]     fifo_tag;
  logic [ADDR_W-1:0]    fifo_addr;
  logic                 fifo_rinc;
  logic [NUM_BANKS-1:0] bank_busy;
  logic [NUM_BANKS-1:0] issue_valid;
  logic [TAG_W-1:0]     issue_tag;
  logic [LADDR_W-1:0]   issue_addr;
  logic [CNT_W-1:0]     issue_count;
  logic [CNT_W-1:0]     stall_count;
  logic                 idle;
  logic [1:0]           state_dbg;

  modport master (
    input  fifo_empty, fifo_valid, fifo_tag, fifo_addr, bank_busy,
    output fifo_rinc, issue_valid, issue_tag, issue_addr, issue_count, stall_count, idle, state_dbg
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_tag, fifo_addr, bank_busy,
    input  fifo_rinc, issue_valid, issue_tag, issue_addr, issue_count, stall_count, idle, state_dbg
  );
endinterface

// File: rtl/fv_req_scheduler.sv
// Pops one FV request at a time from the request FIFO and issues it to its SRAM bank,
// waiting while the bank is busy or was hit by an issue in the previous cycle.
module fv_req_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int TAG_W     = 2,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic reset,
  fv_req_scheduler_if.master bus
);
  localparam int SEL_W   = $clog2(NUM_BANKS);
  localparam int LADDR_W = ADDR_W - SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TAG_W-1:0]     hold_tag_q;
  logic [SEL_W-1:0]     hold_sel_q;
  logic [LADDR_W-1:0]   hold_addr_q;
  logic [NUM_BANKS-1:0] guard_q;
  logic [NUM_BANKS-1:0] issue_valid_q;
  logic [TAG_W-1:0]     issue_tag_q;
  logic [LADDR_W-1:0]   issue_addr_q;
  logic [CNT_W-1:0]     issue_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic                 blocked;
  logic                 rinc;
  logic                 do_capture;
  logic                 do_issue;
  logic                 do_stall;

  // guard_q mirrors last cycle's issue pulse, so a bank is never hit by two consecutive pulses
  assign blocked = bus.bank_busy[hold_sel_q] | guard_q[hold_sel_q];

  always_comb begin
    state_d    = state_q;
    rinc       = 1'b0;
    do_capture = 1'b0;
    do_issue   = 1'b0;
    do_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          rinc    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.fifo_valid) begin
          do_capture = 1'b1;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (blocked) begin
          do_stall = 1'b1;
        end else begin
          do_issue = 1'b1;
          if (!bus.fifo_empty) begin
            rinc    = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_tag_q    <= '0;
      hold_sel_q    <= '0;
      hold_addr_q   <= '0;
      guard_q       <= '0;
      issue_valid_q <= '0;
      issue_tag_q   <= '0;
      issue_addr_q  <= '0;
      issue_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      guard_q       <= issue_valid_q;
      issue_valid_q <= '0;
      if (do_capture) begin
        hold_tag_q  <= bus.fifo_tag;
        hold_sel_q  <= bus.fifo_addr[SEL_W-1:0];
        hold_addr_q <= bus.fifo_addr[ADDR_W-1:SEL_W];
      end
      if (do_issue) begin
        issue_valid_q <= NUM_BANKS'(1) << hold_sel_q;
        issue_tag_q   <= hold_tag_q;
        issue_addr_q  <= hold_addr_q;
        issue_cnt_q   <= issue_cnt_q + CNT_W'(1);
      end
      if (do_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // The pop strobe is decided combinationally, so it is forced low while reset is held
  assign bus.fifo_rinc   = rinc & reset;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_tag   = issue_tag_q;
  assign bus.issue_addr  = issue_addr_q;
  assign bus.issue_count = issue_cnt_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.idle        = (state_q == IDLE);
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_fv_req_scheduler.sv
// Bench for fv_req_scheduler: FIFO responder, request-level reference model with per-cycle compare,
// in-order issue scoreboard, directed scenarios and a randomized phase.
module tb_fv_req_scheduler;
  localparam int NB   = 4;
  localparam int AW   = 10;
  localparam int TW   = 2;
  localparam int CW   = 8;
  localparam int LW   = AW - 2;
  localparam int EW   = 2 + TW + LW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;

  fv_req_scheduler_if #(.NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW), .CNT_W(CW)) bus ();

  fv_req_scheduler #(.NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TW+AW-1:0] fifo_q[$];
  logic [EW-1:0]    exp_q[$];
  int               drop_req = 0;
  int               drop_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [AW-1:0] a);
    fifo_q.push_back({t, a});
  endtask

  // FIFO responder: data follows a sampled pop by one cycle; a pending drop answers with fifo_valid=0
  initial begin : fifo_side
    logic          rinc_seen;
    logic [TW+AW-1:0] item;
    int            a;
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.fifo_tag   = '0;
    bus.fifo_addr  = '0;
    forever begin
      @(negedge clk);
      rinc_seen = bus.fifo_rinc && rst_n;
      @(posedge clk);
      #1;
      if (rinc_seen && fifo_q.size() > 0 && drop_req == drop_done) begin
        item           = fifo_q.pop_front();
        bus.fifo_valid = 1'b1;
        bus.fifo_tag   = item[TW+AW-1:AW];
        bus.fifo_addr  = item[AW-1:0];
        a              = int'(item[AW-1:0]);
        exp_q.push_back({2'(a % NB), item[TW+AW-1:AW], LW'(a / NB)});
      end else begin
        if (rinc_seen && drop_req != drop_done) drop_done++;
        bus.fifo_valid = 1'b0;
        bus.fifo_tag   = TW'($urandom);
        bus.fifo_addr  = AW'($urandom);
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Reference model: one request at most is either being fetched (m_pop) or held (m_held)
  bit m_pop, m_held, m_blocked, m_rinc, m_go;
  int m_req_tag, m_req_addr, m_bank;
  int m_out_bank, m_last_bank, m_out_tag, m_out_laddr, m_issues, m_stalls;
  logic [EW-1:0] sb_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pop = 0; m_held = 0; m_req_tag = 0; m_req_addr = 0;
      m_out_bank = -1; m_last_bank = -1; m_out_tag = 0; m_out_laddr = 0;
      m_issues = 0; m_stalls = 0;
      exp_q.delete();
      check("rst_issue_valid", bus.issue_valid, 0);
      check("rst_issue_tag", bus.issue_tag, 0);
      check("rst_issue_addr", bus.issue_addr, 0);
      check("rst_issue_count", bus.issue_count, 0);
      check("rst_stall_count", bus.stall_count, 0);
      check("rst_rinc", bus.fifo_rinc, 0);
      check("rst_idle", bus.idle, 1);
    end else begin
      check("idle", bus.idle, 32'(!m_pop && !m_held));
      check("issue_valid", bus.issue_valid, (m_out_bank < 0) ? 0 : (1 << m_out_bank));
      check("issue_tag", bus.issue_tag, m_out_tag);
      check("issue_addr", bus.issue_addr, m_out_laddr);
      check("issue_count", bus.issue_count, m_issues % (CMAX + 1));
      check("stall_count", bus.stall_count, m_stalls);
      if (bus.issue_valid != 0) begin
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check("sb_bank", bus.issue_valid, 1 << sb_e[EW-1 -: 2]);
          check("sb_tag", bus.issue_tag, sb_e[LW +: TW]);
          check("sb_addr", bus.issue_addr, sb_e[LW-1:0]);
        end
      end
      m_rinc = 0; m_go = 0;
      m_bank = m_req_addr % NB;
      m_blocked = bus.bank_busy[m_bank] || (m_last_bank == m_bank);
      if (m_pop) begin
        m_pop = 0;
        if (bus.fifo_valid) begin
          m_held = 1; m_req_tag = int'(bus.fifo_tag); m_req_addr = int'(bus.fifo_addr);
        end
      end else if (!m_held) begin
        m_rinc = !bus.fifo_empty; m_pop = m_rinc;
      end else if (m_blocked) begin
        if (m_stalls < CMAX) m_stalls++;
      end else begin
        m_go = 1; m_issues++; m_held = 0;
        m_out_tag = m_req_tag; m_out_laddr = m_req_addr / NB;
        m_rinc = !bus.fifo_empty; m_pop = m_rinc;
      end
      check("fifo_rinc", bus.fifo_rinc, 32'(m_rinc));
      m_last_bank = m_out_bank;
      m_out_bank  = m_go ? m_bank : -1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, s0, i0;
    rst_n = 1'b0;
    bus.bank_busy = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // single request: 0x2D -> bank 1, local 0x0B, three cycles to the pulse
    push(2'd1, 10'h02D);
    n = 0;
    while (bus.fifo_empty && n < 20) begin tick(); n++; end
    check("t1_empty_fell", bus.fifo_empty, 0);
    check("t1_rinc_idle", bus.fifo_rinc, 1);
    n = 0;
    while (bus.issue_valid == 0 && n < 20) begin tick(); n++; end
    check("t1_latency", n, 3);
    check("t1_valid", bus.issue_valid, 4'b0010);
    check("t1_addr", bus.issue_addr, 8'h0B);
    check("t1_tag", bus.issue_tag, 1);
    check("t1_count", bus.issue_count, 1);

    // back-to-back on bank 1: guard adds one stall cycle
    repeat (3) tick();
    s0 = int'(bus.stall_count);
    push(2'd0, 10'h001);
    push(2'd2, 10'h005);
    n = 0;
    while (bus.issue_valid == 0 && n < 20) begin tick(); n++; end
    check("t2_first_addr", bus.issue_addr, 0);
    tick();
    n = 1;
    while (bus.issue_valid == 0 && n < 20) begin tick(); n++; end
    check("t2_gap", n, 3);
    check("t2_second_valid", bus.issue_valid, 4'b0010);
    check("t2_second_addr", bus.issue_addr, 1);
    check("t2_stall", bus.stall_count, s0 + 1);

    // bank 2 busy for 5 held cycles
    repeat (3) tick();
    s0 = int'(bus.stall_count);
    bus.bank_busy = 4'b0100;
    push(2'd3, 10'h006);
    n = 0;
    while (int'(bus.stall_count) == s0 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      check("t3_no_issue", bus.issue_valid, 0);
      tick();
    end
    check("t3_stall5", bus.stall_count, s0 + 5);
    bus.bank_busy = '0;
    tick();
    check("t3_valid", bus.issue_valid, 4'b0100);
    check("t3_addr", bus.issue_addr, 1);
    check("t3_stall_hold", bus.stall_count, s0 + 5);

    // fifo_valid=0 in WAIT: back to IDLE with nothing captured
    repeat (3) tick();
    i0 = int'(bus.issue_count);
    s0 = int'(bus.stall_count);
    drop_req++;
    push(2'd2, 10'h013);
    n = 0;
    while (bus.fifo_empty && n < 20) begin tick(); n++; end
    tick();
    tick();
    check("t4_idle", bus.idle, 1);
    check("t4_count", bus.issue_count, i0);
    check("t4_stall", bus.stall_count, s0);
    n = 0;
    while (bus.issue_valid == 0 && n < 20) begin tick(); n++; end
    check("t4_retry_count", bus.issue_count, i0 + 1);

    // reset while blocked in ISSUE discards the request
    repeat (3) tick();
    bus.bank_busy = 4'b1000;
    push(2'd1, 10'h00F);
    s0 = int'(bus.stall_count);
    n = 0;
    while (int'(bus.stall_count) == s0 && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    check("t5_idle_async", bus.idle, 1);
    check("t5_count_async", bus.issue_count, 0);
    tick();
    tick();
    bus.bank_busy = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_no_issue", bus.issue_valid, 0);
    end
    check("t5_count_after", bus.issue_count, 0);

    // stall counter saturates
    bus.bank_busy = 4'b0001;
    push(2'd2, 10'h000);
    repeat (CMAX + 20) tick();
    check("t6_saturated", bus.stall_count, CMAX);
    bus.bank_busy = '0;
    n = 0;
    while (bus.issue_valid == 0 && n < 20) begin tick(); n++; end
    check("t6_valid", bus.issue_valid, 4'b0001);
    check("t6_sat_hold", bus.stall_count, CMAX);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NB; b++) bus.bank_busy[b] = ($urandom_range(0, 3) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) push(TW'($urandom), AW'($urandom));
      if (drop_req == drop_done && $urandom_range(0, 15) == 0) drop_req++;
      tick();
    end
    bus.bank_busy = '0;
    n = 0;
    while ((fifo_q.size() != 0 || !bus.idle) && n < 200) begin tick(); n++; end
    tick();
    tick();
    check("drain_fifo", fifo_q.size(), 0);
    check("drain_idle", bus.idle, 1);
    check("drain_sb", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fv_req_scheduler.md
FV_REQ_SCHEDULER -- requirements
Module: fv_req_scheduler

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of FV SRAM banks; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_W, default 10, global FV address width.
REQ-003 Parameter TAG_W, default 2, Edge PE tag width.
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 fifo_empty  in  1  request FIFO empty flag.
REQ-008 fifo_valid  in  1  FIFO read data valid, one cycle after fifo_rinc.
REQ-009 fifo_tag  in  TAG_W  requesting PE tag.
REQ-010 fifo_addr  in  ADDR_W  global FV address.
REQ-011 fifo_rinc  out  1  FIFO pop strobe.
REQ-012 bank_busy  in  NUM_BANKS  per-bank busy flags.
REQ-013 issue_valid  out  NUM_BANKS  one-hot bank issue strobe.
REQ-014 issue_tag  out  TAG_W  tag of the issued request.
REQ-015 issue_addr  out  ADDR_W-log2(NUM_BANKS)  bank-local address.
REQ-016 issue_count  out  CNT_W  total requests issued.
REQ-017 stall_count  out  CNT_W  cycles spent blocked on a busy bank.
REQ-018 idle  out  1  high when in IDLE with no held request.

Function
REQ-019 Bank select SHALL be fifo_addr[log2(NUM_BANKS)-1:0]; the local address SHALL be the remaining upper bits.
REQ-020 FSM states SHALL be IDLE, WAIT, ISSUE.
REQ-021 IDLE: if fifo_empty=0, assert fifo_rinc for one cycle and go to WAIT; otherwise stay.
REQ-022 WAIT: if fifo_valid=1, capture tag, select and local address into the hold register and go to ISSUE; if fifo_valid=0, go to IDLE and capture nothing.
REQ-023 ISSUE: the target is blocked when bank_busy[sel]=1 or the same bank was issued in the previous cycle (one-cycle guard mask).
REQ-024 ISSUE, not blocked: drive issue_valid one-hot at sel for exactly one cycle, with issue_tag and issue_addr taken from the hold register.
REQ-025 In the same cycle, increment issue_count (wrap modulo 2^CNT_W), then: if fifo_empty=0, assert fifo_rinc and go to WAIT; else go to IDLE.
REQ-026 ISSUE, blocked: stay in ISSUE, keep the hold register unchanged, and increment stall_count, saturating at all-ones.
REQ-027 fifo_rinc SHALL never be asserted in WAIT or while blocked; at most one request SHALL be outstanding.
REQ-028 issue_valid SHALL be registered, and SHALL be zero in every cycle except an issue cycle.
REQ-029 issue_tag and issue_addr SHALL hold their last value when no issue occurs.
REQ-030 A bank_busy change during ISSUE SHALL take effect in the same cycle (combinational check, registered issue).
REQ-031 idle SHALL be 1 only in IDLE.

Reset
REQ-032 While reset=0: state=IDLE; hold register, guard mask, issue_valid, issue_tag, issue_addr, fifo_rinc, issue_count and stall_count = 0; idle=1.
REQ-033 Reset asserted mid-WAIT or mid-ISSUE SHALL discard the held request without issuing it; the first cycle after release SHALL behave as IDLE.

Verification
REQ-034 Single request, NUM_BANKS=4, addr=0x2D, tag=1, banks idle -> rinc in IDLE; issue_valid=4'b0010, issue_addr=0x0B, tag=1, issue_count=1; 3 cycles from fifo_empty falling to the issue pulse.
REQ-035 Back-to-back addrs 0x01, 0x05 (both bank 1) -> second issue delayed by the guard, at least 1 extra cycle; stall_count increments by 1; both issued in order.
REQ-036 bank_busy[2]=1 for 5 cycles with addr 0x06 held -> stall_count=5, no issue_valid; issue on the cycle busy drops.
REQ-037 fifo_valid=0 in WAIT -> return to IDLE; no issue; counters unchanged.
REQ-038 reset pulled low while blocked in ISSUE -> all outputs 0, idle=1; after release with fifo_empty=1, no issue ever occurs.
REQ-039 stall_count preloaded to saturation (2^CNT_W-1 cycles blocked) -> it holds at all-ones.
